// File: rtl/div_controller.sv
// div_controller
// Multi-cycle sequencer for 32-bit non-restoring division (DIV / DIVU).
// Runs one non-restoring step per clock on a WIDTH+1-bit accumulator, then a
// correction step that also applies the sign fix-up and loads the results.
//
// Handshake: a request is taken at a rising edge where start=1 and busy=0
// (states IDLE or DONE). Operands and signed_op are sampled only at that
// edge. busy is high while the operation runs (ITER, FIX). done pulses for
// exactly one cycle when quotient/remainder/div_by_zero are valid. A start
// seen while busy=1 is dropped.
//
// Ports:
//   clock        rising-edge clock
//   clear_n      asynchronous active-low reset
//   start        request strobe
//   signed_op    1 = signed DIV, 0 = unsigned DIVU
//   dividend     Q operand
//   divisor      M operand
//   busy         high in ITER and FIX
//   done         one-cycle pulse in DONE
//   div_by_zero  set by a divide-by-zero request, cleared by the next capture
//   quotient     result, held until the next result load
//   remainder    result, held until the next result load
//   o_dbg_state  current FSM state (0 IDLE, 1 ITER, 2 FIX, 3 DONE)
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic             w_accept;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_m_mag;
  logic [WIDTH:0]   w_a_shift;
  logic [WIDTH:0]   w_a_step;
  logic [WIDTH:0]   w_a_fix;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_div_zero = (divisor == '0);

  // Magnitudes wrap modulo 2^WIDTH, so the most negative value maps to 2^(WIDTH-1).
  assign w_q_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_m_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  // One non-restoring step: shift {A,Q} left, then subtract or add M
  // depending on the sign of A before the shift.
  assign w_a_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_a_step  = r_a[WIDTH] ? (w_a_shift + {1'b0, r_m})
                                : (w_a_shift - {1'b0, r_m});

  // Final correction brings a negative partial remainder back into range.
  assign w_a_fix = r_a[WIDTH] ? (r_a + {1'b0, r_m}) : r_a;

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next_state = w_div_zero ? S_DONE : S_ITER;
        else          w_next_state = S_IDLE;
      end
      S_ITER:  if (r_cnt == CW'(WIDTH - 1)) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode (state-only, so no input-to-output path)
  always_comb begin
    busy        = (r_state == S_ITER) || (r_state == S_FIX);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  assign div_by_zero = r_dbz;
  assign quotient    = r_quot;
  assign remainder   = r_rem;

  // Datapath
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_div_zero) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_q     <= w_q_mag;
              r_m     <= w_m_mag;
              r_a     <= '0;
              r_cnt   <= '0;
              r_q_neg <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_r_neg <= signed_op && dividend[WIDTH-1];
              r_dbz   <= 1'b0;
            end
          end
        end
        S_ITER: begin
          r_a   <= w_a_step;
          r_q   <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_a    <= w_a_fix;
          r_quot <= r_q_neg ? -r_q : r_q;
          r_rem  <= r_r_neg ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
module tb_div_controller;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  div_controller #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, then wait (bounded) for done. lat counts edges after
  // E0 until done is seen; busy_cyc counts samples with busy high before done.
  // If inject >= 0, a divide-by-zero start is pulsed that many edges after E0.
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int lat, output int busy_cyc);
    @(negedge clock);
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clock);   // E0
    #1;
    start     = 1'b0;
    // Garbage operands after capture must not matter.
    dividend  = $urandom;
    divisor   = $urandom_range(1, 1000);
    signed_op = 1'($urandom_range(0, 1));
    lat       = 0;
    busy_cyc  = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      if (lat == inject) begin
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
  endtask

  int lat;
  int bcyc;
  int done_seen;

  initial begin
    clear_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem",  remainder, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;

    // Unsigned 100/7: busy covers 32 ITER cycles plus FIX
    run_op(1'b0, 32'd100, 32'd7, -1, lat, bcyc);
    check("u100_7_lat",  32'(lat), 32'd33);
    check("u100_7_busy", 32'(bcyc), 32'd33);
    check("u100_7_q",    quotient, 32'd14);
    check("u100_7_r",    remainder, 32'd2);
    check("u100_7_dbz",  32'(div_by_zero), 32'd0);
    check("u100_7_busy_at_done", 32'(busy), 32'd0);
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);

    // Signed -7/2 and 7/-2
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, bcyc);
    check("s_m7_2_q", quotient, 32'hFFFF_FFFD);
    check("s_m7_2_r", remainder, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, lat, bcyc);
    check("s_7_m2_q", quotient, 32'hFFFF_FFFD);
    check("s_7_m2_r", remainder, 32'd1);

    // Unsigned full-range
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, lat, bcyc);
    check("u_max_1_q", quotient, 32'hFFFF_FFFF);
    check("u_max_1_r", remainder, 32'd0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, -1, lat, bcyc);
    check("u_big_div_q", quotient, 32'd0);
    check("u_big_div_r", remainder, 32'h7FFF_FFFF);

    // Divide by zero: done visible right after E0, busy never high
    run_op(1'b0, 32'd5, 32'd0, -1, lat, bcyc);
    check("dz_lat",  32'(lat), 32'd0);
    check("dz_busy", 32'(bcyc), 32'd0);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    check("dz_q",    quotient, 32'hFFFF_FFFF);
    check("dz_r",    remainder, 32'd5);
    @(posedge clock); #1;
    check("dz_flag_held", 32'(div_by_zero), 32'd1);
    check("dz_done_drop", 32'(done), 32'd0);
    run_op(1'b0, 32'd20, 32'd6, -1, lat, bcyc);
    check("dz_cleared", 32'(div_by_zero), 32'd0);
    check("u20_6_q", quotient, 32'd3);
    check("u20_6_r", remainder, 32'd2);

    // Signed overflow case, then back-to-back start in the DONE cycle
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bcyc);
    check("ovf_q",    quotient, 32'h8000_0000);
    check("ovf_r",    remainder, 32'd0);
    check("ovf_flag", 32'(div_by_zero), 32'd0);
    check("ovf_in_done", 32'(done), 32'd1);
    run_op(1'b1, 32'd9, 32'd3, -1, lat, bcyc);
    check("b2b_lat", 32'(lat), 32'd33);
    check("b2b_q",   quotient, 32'd3);
    check("b2b_r",   remainder, 32'd0);

    // Reset pulse mid-ITER at E10 of a 100/7 op
    @(negedge clock);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);   // E0
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);   // E9
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q",    quotient, 32'd0);
    check("abort_r",    remainder, 32'd0);
    @(negedge clock);   // held low across E10
    clear_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // A start during ITER is ignored
    run_op(1'b0, 32'd1000, 32'd10, 5, lat, bcyc);
    check("ign_lat",  32'(lat), 32'd33);
    check("ign_q",    quotient, 32'd100);
    check("ign_r",    remainder, 32'd0);
    check("ign_flag", 32'(div_by_zero), 32'd0);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
